// File: rtl/irrigation_actuator_sequencer.sv
// ---------------------------------------------------------------------------
// irrigation_actuator_sequencer
//
// Sequences the irrigation actuators so that the sprinkler pump and the
// dripper valve are never on together. Each run lasts a minimum on-time and
// is followed by a dead-time with both actuators off. An alarm request forces
// a lockout that is only released after the alarm has stayed low for a number
// of consecutive cycles. The supply valve simply follows its request one
// cycle late and is not affected by the sequencer state.
//
// Parameters:
//   MIN_ON_CYCLES     minimum cycles a started run stays on (1..65535)
//   MIN_OFF_CYCLES    dead-time cycles between runs (1..65535)
//   ALARM_HOLD_CYCLES consecutive alarm-low cycles ending a lockout (1..65535)
//
// Ports:
//   clk                   single clock, rising edge
//   reset                 synchronous, active-high reset
//   splinker_request      sprinkler-pump request
//   dripper_request       dripper-valve request
//   alarm_request         alarm condition
//   water_supply_request  supply-valve request
//   splinker_pump_en      sprinkler pump drive (registered)
//   dripper_valve_en      dripper valve drive (registered)
//   water_supply_valve_en supply valve drive (registered)
//   alarm_out             alarm annunciator drive (registered)
//   state                 current FSM state code (debug)
// ---------------------------------------------------------------------------
module irrigation_actuator_sequencer #(
  parameter logic [15:0] MIN_ON_CYCLES     = 16'd4,
  parameter logic [15:0] MIN_OFF_CYCLES    = 16'd2,
  parameter logic [15:0] ALARM_HOLD_CYCLES = 16'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       splinker_request,
  input  logic       dripper_request,
  input  logic       alarm_request,
  input  logic       water_supply_request,
  output logic       splinker_pump_en,
  output logic       dripper_valve_en,
  output logic       water_supply_valve_en,
  output logic       alarm_out,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SPRINKLE  = 3'd1,
    ST_DRIP      = 3'd2,
    ST_DEAD_TIME = 3'd3,
    ST_LOCKOUT   = 3'd4
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [15:0] cnt_r;
  logic        cnt_clear_s;
  logic [16:0] cnt_plus_one_s;
  logic        on_done_s;
  logic        off_done_s;
  logic        hold_done_s;
  logic        pump_r;
  logic        drip_r;
  logic        alarm_r;
  logic        supply_r;

  // cnt_r + 1 is the number of cycles spent in the current state including
  // this one; widened to 17 bits so a saturated counter still compares right.
  assign cnt_plus_one_s = {1'b0, cnt_r} + 17'd1;
  assign on_done_s      = (cnt_plus_one_s >= {1'b0, MIN_ON_CYCLES});
  assign off_done_s     = (cnt_plus_one_s >= {1'b0, MIN_OFF_CYCLES});
  assign hold_done_s    = (cnt_plus_one_s >= {1'b0, ALARM_HOLD_CYCLES});

  // Next-state decode; alarm overrides every state, entries clear the counter.
  always_comb begin
    next_state_s = state_r;
    cnt_clear_s  = 1'b0;
    if (alarm_request) begin
      // Also taken while already in lockout: restarts the low-sample count.
      next_state_s = ST_LOCKOUT;
      cnt_clear_s  = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (splinker_request) begin
            next_state_s = ST_SPRINKLE;
            cnt_clear_s  = 1'b1;
          end else if (dripper_request) begin
            next_state_s = ST_DRIP;
            cnt_clear_s  = 1'b1;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_SPRINKLE: begin
          if (on_done_s && !splinker_request) begin
            next_state_s = ST_DEAD_TIME;
            cnt_clear_s  = 1'b1;
          end else begin
            next_state_s = ST_SPRINKLE;
          end
        end
        ST_DRIP: begin
          if (on_done_s && !dripper_request) begin
            next_state_s = ST_DEAD_TIME;
            cnt_clear_s  = 1'b1;
          end else begin
            next_state_s = ST_DRIP;
          end
        end
        ST_DEAD_TIME: begin
          if (off_done_s) begin
            next_state_s = ST_IDLE;
            cnt_clear_s  = 1'b1;
          end else begin
            next_state_s = ST_DEAD_TIME;
          end
        end
        ST_LOCKOUT: begin
          // Alarm is low here; the counter holds consecutive low samples.
          if (hold_done_s) begin
            next_state_s = ST_DEAD_TIME;
            cnt_clear_s  = 1'b1;
          end else begin
            next_state_s = ST_LOCKOUT;
          end
        end
        default: begin
          // Unused codes recover through a safe all-off dead-time.
          next_state_s = ST_DEAD_TIME;
          cnt_clear_s  = 1'b1;
        end
      endcase
    end
  end

  // State register and registered actuator drives decoded from next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      pump_r  <= 1'b0;
      drip_r  <= 1'b0;
      alarm_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      pump_r  <= (next_state_s == ST_SPRINKLE);
      drip_r  <= (next_state_s == ST_DRIP);
      alarm_r <= (next_state_s == ST_LOCKOUT);
    end
  end

  // Shared state-time counter: cleared on entry, saturating increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 16'd0;
    end else if (cnt_clear_s) begin
      cnt_r <= 16'd0;
    end else if (cnt_r != 16'hFFFF) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Supply valve follows its request one cycle late, independent of state.
  always_ff @(posedge clk) begin
    if (reset) begin
      supply_r <= 1'b0;
    end else begin
      supply_r <= water_supply_request;
    end
  end

  assign splinker_pump_en      = pump_r;
  assign dripper_valve_en      = drip_r;
  assign alarm_out             = alarm_r;
  assign water_supply_valve_en = supply_r;
  assign state                 = state_r;

endmodule

// File: tb/tb_irrigation_actuator_sequencer.sv
// ---------------------------------------------------------------------------
// tb_irrigation_actuator_sequencer
//
// Directed bench for irrigation_actuator_sequencer with default parameters.
// Inputs are driven with blocking assignments; each tick waits for a rising
// edge and then 1 time unit, so outputs are observed in the cycle following
// that edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_irrigation_actuator_sequencer;

  logic       clk;
  logic       reset;
  logic       splinker_request;
  logic       dripper_request;
  logic       alarm_request;
  logic       water_supply_request;
  logic       splinker_pump_en;
  logic       dripper_valve_en;
  logic       water_supply_valve_en;
  logic       alarm_out;
  logic [2:0] state;

  int check_count = 0;
  int error_count = 0;
  logic water_level = 1'b0;

  irrigation_actuator_sequencer dut (
    .clk                   (clk),
    .reset                 (reset),
    .splinker_request      (splinker_request),
    .dripper_request       (dripper_request),
    .alarm_request         (alarm_request),
    .water_supply_request  (water_supply_request),
    .splinker_pump_en      (splinker_pump_en),
    .dripper_valve_en      (dripper_valve_en),
    .water_supply_valve_en (water_supply_valve_en),
    .alarm_out             (alarm_out),
    .state                 (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [7:0] got, input logic [7:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One lockout-phase cycle with the supply request toggling each call.
  task automatic lockout_step(input logic a, input logic exp_alarm, input logic [2:0] exp_state);
    alarm_request        = a;
    water_supply_request = water_level;
    tick();
    check_value("lock_alarm_out", {7'd0, alarm_out}, {7'd0, exp_alarm});
    check_value("lock_state", {5'd0, state}, {5'd0, exp_state});
    check_value("lock_supply", {7'd0, water_supply_valve_en}, {7'd0, water_level});
    water_level = ~water_level;
  endtask

  // Pump and dripper must never be on together.
  always @(negedge clk) begin
    if (!reset) begin
      check_value("mutex", {7'd0, splinker_pump_en & dripper_valve_en}, 8'd0);
    end
  end

  logic [2:0] exp29 [7];

  initial begin
    exp29 = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd0};

    // Reset held two cycles with every request high, alarm included.
    reset = 1'b1;
    splinker_request = 1'b1;
    dripper_request = 1'b1;
    alarm_request = 1'b1;
    water_supply_request = 1'b1;
    tick();
    tick();
    check_value("rst_state", {5'd0, state}, 8'd0);
    check_value("rst_pump", {7'd0, splinker_pump_en}, 8'd0);
    check_value("rst_drip", {7'd0, dripper_valve_en}, 8'd0);
    check_value("rst_alarm", {7'd0, alarm_out}, 8'd0);
    check_value("rst_supply", {7'd0, water_supply_valve_en}, 8'd0);

    // Release: sprinkler wins over dripper one cycle later.
    alarm_request = 1'b0;
    reset = 1'b0;
    tick();
    check_value("rel_state", {5'd0, state}, 8'd1);
    check_value("rel_pump", {7'd0, splinker_pump_en}, 8'd1);
    check_value("rel_supply", {7'd0, water_supply_valve_en}, 8'd1);

    // Reset mid-run aborts straight to idle with no dead-time.
    splinker_request = 1'b0;
    dripper_request = 1'b0;
    water_supply_request = 1'b0;
    reset = 1'b1;
    tick();
    check_value("abort_state", {5'd0, state}, 8'd0);
    check_value("abort_pump", {7'd0, splinker_pump_en}, 8'd0);
    reset = 1'b0;
    tick();
    check_value("abort_idle", {5'd0, state}, 8'd0);

    // Single-cycle sprinkler pulse: full 4-cycle run, 2 dead, then idle.
    splinker_request = 1'b1;
    tick();
    splinker_request = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check_value("pulse_state", {5'd0, state}, {5'd0, exp29[i]});
      check_value("pulse_pump", {7'd0, splinker_pump_en}, {7'd0, exp29[i] == 3'd1});
      if (i < 6) tick();
    end

    // Both requests held: sprinkler stays on, dripper waits for its turn.
    splinker_request = 1'b1;
    dripper_request = 1'b1;
    tick();
    for (int i = 1; i <= 10; i++) begin
      check_value("both_pump", {7'd0, splinker_pump_en}, 8'd1);
      check_value("both_drip", {7'd0, dripper_valve_en}, 8'd0);
      if (i < 10) tick();
    end
    splinker_request = 1'b0;
    tick();
    check_value("both_dead1", {5'd0, state}, 8'd3);
    tick();
    check_value("both_dead2", {5'd0, state}, 8'd3);
    tick();
    check_value("both_idle", {5'd0, state}, 8'd0);
    tick();
    check_value("both_drip_state", {5'd0, state}, 8'd2);
    check_value("both_drip_on", {7'd0, dripper_valve_en}, 8'd1);
    check_value("both_drip_pump", {7'd0, splinker_pump_en}, 8'd0);
    dripper_request = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Alarm during sprinkling overrides the minimum on-time.
    splinker_request = 1'b1;
    tick();
    splinker_request = 1'b0;
    tick();
    check_value("alm_run", {5'd0, state}, 8'd1);
    alarm_request = 1'b1;
    tick();
    check_value("alm_pump_off", {7'd0, splinker_pump_en}, 8'd0);
    check_value("alm_on", {7'd0, alarm_out}, 8'd1);
    check_value("alm_state", {5'd0, state}, 8'd4);
    tick();
    tick();
    check_value("alm_c5", {7'd0, alarm_out}, 8'd1);
    alarm_request = 1'b0;
    tick();
    check_value("alm_c6", {7'd0, alarm_out}, 8'd1);
    tick();
    check_value("alm_c7", {7'd0, alarm_out}, 8'd1);
    tick();
    check_value("alm_c8_state", {5'd0, state}, 8'd3);
    check_value("alm_c8_off", {7'd0, alarm_out}, 8'd0);
    tick();
    check_value("alm_c9_state", {5'd0, state}, 8'd3);
    tick();
    check_value("alm_c10_state", {5'd0, state}, 8'd0);

    // Lockout hold restart plus supply-valve toggling.
    alarm_request = 1'b1;
    tick();
    check_value("hold_enter", {5'd0, state}, 8'd4);
    lockout_step(1'b0, 1'b1, 3'd4);
    lockout_step(1'b0, 1'b1, 3'd4);
    lockout_step(1'b1, 1'b1, 3'd4);
    lockout_step(1'b0, 1'b1, 3'd4);
    lockout_step(1'b0, 1'b1, 3'd4);
    lockout_step(1'b0, 1'b0, 3'd3);

    // Alarm during dead-time forces lockout again.
    lockout_step(1'b1, 1'b1, 3'd4);
    lockout_step(1'b0, 1'b1, 3'd4);
    lockout_step(1'b0, 1'b1, 3'd4);
    lockout_step(1'b0, 1'b0, 3'd3);
    tick();
    check_value("dt_hold", {5'd0, state}, 8'd3);
    tick();
    check_value("dt_idle", {5'd0, state}, 8'd0);

    // Reset clears the supply valve even with its request high.
    water_supply_request = 1'b1;
    tick();
    check_value("supply_pre", {7'd0, water_supply_valve_en}, 8'd1);
    reset = 1'b1;
    tick();
    check_value("supply_rst", {7'd0, water_supply_valve_en}, 8'd0);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
